// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared status type and elaboration helpers for sync_fifo_prog
package sync_fifo_pkg;
   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
      logic overflow;
      logic underflow;
   } fifo_status_t;
   function automatic bit is_pow2(input int n);
      return n > 0 && (n & (n - 1)) == 0;
   endfunction
endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: storage array, registered read port or asynchronous read port under SYNC_FIFO_FWFT_EN
module sync_fifo_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH = 256,
   localparam int PTR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
`ifndef SYNC_FIFO_FWFT_EN
   input  logic                  rst,
   input  logic                  re,
`endif
   input  logic                  we,
   input  logic [PTR_WIDTH-1:0]  waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [PTR_WIDTH-1:0]  raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
`ifdef SYNC_FIFO_FWFT_EN
   assign rdata = mem[raddr];
`else
   always_ff @(posedge clk)
      if (rst) rdata <= '0;
      else if (re) rdata <= mem[raddr];
`endif
endmodule

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with programmable thresholds, sticky errors, FWFT under SYNC_FIFO_FWFT_EN
module sync_fifo_prog
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH = 256,
   localparam int PTR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  w_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  r_en,
   output logic [DATA_WIDTH-1:0] data_out,
   input  logic [PTR_WIDTH:0]    af_level,
   input  logic [PTR_WIDTH:0]    ae_level,
   input  logic                  err_clr,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [PTR_WIDTH:0]    count,
   output logic                  overflow,
   output logic                  underflow
);
   if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
      $error("sync_fifo_prog: DEPTH must be a power of 2 and >= 4");
   end
   logic [PTR_WIDTH-1:0]  waddr, raddr;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rd_acc, wr_acc;
   assign full         = count == (PTR_WIDTH+1)'(DEPTH);
   assign empty        = count == '0;
   assign almost_full  = count >= af_level;
   assign almost_empty = count <= ae_level;
   assign rd_acc       = r_en & ~empty;
   assign wr_acc       = w_en & (~full | rd_acc);
   always_ff @(posedge clk)
      if (rst) begin
         waddr     <= '0;
         raddr     <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         waddr     <= waddr + PTR_WIDTH'(wr_acc);
         raddr     <= raddr + PTR_WIDTH'(rd_acc);
         count     <= count + (PTR_WIDTH+1)'(wr_acc) - (PTR_WIDTH+1)'(rd_acc);
         overflow  <= (w_en & ~wr_acc) | (overflow & ~err_clr);
         underflow <= (r_en & ~rd_acc) | (underflow & ~err_clr);
      end
   sync_fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
      .clk   (clk),
`ifndef SYNC_FIFO_FWFT_EN
      .rst   (rst),
      .re    (rd_acc),
`endif
      .we    (wr_acc & ~rst),
      .waddr (waddr),
      .wdata (data_in),
      .raddr (raddr),
      .rdata (rdata)
   );
`ifdef SYNC_FIFO_FWFT_EN
   assign data_out = empty ? '0 : rdata;
`else
   assign data_out = rdata;
`endif
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: directed plus random stimulus against a queue-based FIFO model
module tb_sync_fifo_prog;
   import sync_fifo_pkg::*;
   localparam int D = 16;
   logic clk = 0, rst = 1, w_en = 0, r_en = 0, err_clr = 0;
   logic [7:0] data_in = 0, data_out;
   logic [4:0] af_level = 14, ae_level = 2, count;
   logic full, empty, almost_full, almost_empty, overflow, underflow;
   int vectors = 0, errors = 0;
   byte unsigned q[$];
   logic [7:0] dout_m = 0;
   bit ovf_m = 0, unf_m = 0;
   always #5 clk = ~clk;
   sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
      .data_out(data_out), .af_level(af_level), .ae_level(ae_level),
      .err_clr(err_clr), .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic verify();
      fifo_status_t s_got, s_exp;
      s_got = '{full, empty, almost_full, almost_empty, overflow, underflow};
      s_exp = '{q.size() == D, q.size() == 0, q.size() >= int'(af_level),
                q.size() <= int'(ae_level), ovf_m, unf_m};
      check("count", 32'(count), 32'(q.size()));
      check("status", 32'(s_got), 32'(s_exp));
      check("data_out", 32'(data_out), 32'(dout_m));
   endtask
   task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit c = 0);
      bit ra, wa;
      w_en = w; data_in = d; r_en = r; err_clr = c;
      ra = r && q.size() > 0;
      wa = w && (q.size() < D || ra);
      @(posedge clk);
`ifndef SYNC_FIFO_FWFT_EN
      if (ra) dout_m = q[0];
`endif
      if (ra) void'(q.pop_front());
      if (wa) q.push_back(d);
      ovf_m = (w && !wa) || (ovf_m && !c);
      unf_m = (r && !ra) || (unf_m && !c);
      @(negedge clk);
      w_en = 0; r_en = 0; err_clr = 0;
`ifdef SYNC_FIFO_FWFT_EN
      dout_m = q.size() > 0 ? q[0] : 8'h00;
`endif
      verify();
   endtask
   task automatic reset_fifo();
      rst = 1; w_en = 1; r_en = 1; data_in = 8'($urandom);
      @(posedge clk);
      q.delete(); dout_m = 0; ovf_m = 0; unf_m = 0;
      @(negedge clk);
      rst = 0; w_en = 0; r_en = 0;
      verify();
   endtask
   initial begin
      reset_fifo();
      for (int i = 1; i <= D; i++) cyc(1, 8'(i), 0);
      check("fill_full", 32'(full), 1);
      cyc(1, 8'hAA, 0);
      check("ovf_set", 32'(overflow), 1);
      cyc(0, 0, 0, 1);
      check("ovf_clr", 32'(overflow), 0);
      cyc(1, 8'hAA, 0);
      cyc(1, 8'hBB, 0, 1);
      check("ovf_set_wins", 32'(overflow), 1);
      cyc(0, 0, 0, 1);
      for (int i = 1; i <= D; i++) cyc(0, 0, 1);
      check("drain_empty", 32'(empty), 1);
      cyc(0, 0, 1);
      check("unf_set", 32'(underflow), 1);
      cyc(0, 0, 0, 1);
      for (int i = 0; i < D; i++) cyc(1, 8'($urandom), 0);
      cyc(1, 8'h77, 1);
      check("full_rw_full", 32'(full), 1);
      for (int i = 0; i < D; i++) cyc(0, 0, 1);
      cyc(1, 8'h33, 1);
      check("empty_rw_cnt", 32'(count), 1);
      cyc(0, 0, 1, 1);
      for (int i = 0; i < 40; i++) begin
         cyc(1, 8'($urandom), 0);
         cyc(0, 0, 1);
      end
      for (int i = 0; i < 9; i++) cyc(1, 8'($urandom), 0);
      check("pre_rst_cnt", 32'(count), 9);
      reset_fifo();
      check("rst_empty", 32'(empty), 1);
      cyc(1, 8'h5C, 0);
`ifdef SYNC_FIFO_FWFT_EN
      check("fwft_5c", 32'(data_out), 32'h5C);
`endif
      for (int i = 0; i < 600; i++) begin
         int bias;
         bias = (i / 100) % 2 ? 30 : 70;
         if ($urandom_range(0, 19) == 0) begin
            af_level = 5'($urandom_range(0, 17));
            ae_level = 5'($urandom_range(0, 17));
         end
         if (i == 450) reset_fifo();
         cyc($urandom_range(0, 99) < bias, 8'($urandom), $urandom_range(0, 99) >= bias - 20,
             $urandom_range(0, 15) == 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
